// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types for the decode/execute boundary.
// The decoder and this stage both rely on CTRL_W and on the ID/EX register layout.
package id_ex_stage_pkg;

  localparam int CTRL_W = 16;

  typedef logic [31:0] u32_t;
  typedef logic [4:0]  regaddr_t;

  typedef struct packed {
    logic              valid;
    regaddr_t          ra_addr;
    regaddr_t          rb_addr;
    regaddr_t          rd_addr;
    u32_t              ra_data;
    u32_t              rb_data;
    u32_t              imm;
    logic [CTRL_W-1:0] ctrl;
    logic              is_load;
  } id_ex_t;

  // An all-zero register is a bubble: valid=0 and rd=0, so it never matches a live source.
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use interlock and IF/ID stall generation.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic     id_valid,
  input  regaddr_t id_ra_addr,
  input  regaddr_t id_rb_addr,
  input  logic     ex_valid,
  input  logic     ex_is_load,
  input  regaddr_t ex_rd_addr,
  input  logic     ex_redirect,
  input  logic     mem_busy,
  output logic     load_use,
  output logic     stall_if_id
);

  logic src_match;

  assign src_match = (ex_rd_addr == id_ra_addr) || (ex_rd_addr == id_rb_addr);

  // r0 is never written, so a load targeting it cannot create a dependency.
  assign load_use = id_valid && ex_valid && ex_is_load && (ex_rd_addr != '0) && src_match;

  // A redirect discards the ID instruction upstream, so the interlock is moot.
  assign stall_if_id = mem_busy || (load_use && !ex_redirect);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush on redirect,
// freeze on MEM back-pressure and a saturating load-use bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  regaddr_t          id_ra_addr,
  input  regaddr_t          id_rb_addr,
  input  regaddr_t          id_rd_addr,
  input  u32_t              id_ra_data,
  input  u32_t              id_rb_data,
  input  u32_t              id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              stall_if_id,
  output logic              valid_id_ex,
  output regaddr_t          ra_addr_id_ex,
  output regaddr_t          rb_addr_id_ex,
  output regaddr_t          rd_addr_id_ex,
  output u32_t              ra_data_id_ex,
  output u32_t              rb_data_id_ex,
  output u32_t              imm_id_ex,
  output logic [CTRL_W-1:0] ctrl_id_ex,
  output logic              is_load_id_ex,
  output logic [CNT_W-1:0]  lu_bubble_cnt
);

  id_ex_t            stage_reg;
  id_ex_t            capture_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .id_ra_addr  (id_ra_addr),
    .id_rb_addr  (id_rb_addr),
    .ex_valid    (stage_reg.valid),
    .ex_is_load  (stage_reg.is_load),
    .ex_rd_addr  (stage_reg.rd_addr),
    .ex_redirect (ex_redirect),
    .mem_busy    (mem_busy),
    .load_use    (load_use),
    .stall_if_id (stall_if_id)
  );

  // An empty ID slot is captured as a full bubble so stale fields never reach EX.
  always_comb begin
    capture_next = ID_EX_BUBBLE;
    if (id_valid) begin
      capture_next.valid   = 1'b1;
      capture_next.ra_addr = id_ra_addr;
      capture_next.rb_addr = id_rb_addr;
      capture_next.rd_addr = id_rd_addr;
      capture_next.ra_data = id_ra_data;
      capture_next.rb_data = id_rb_data;
      capture_next.imm     = id_imm;
      capture_next.ctrl    = id_ctrl;
      capture_next.is_load = id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= ID_EX_BUBBLE;
      cnt_reg   <= '0;
    end else if (mem_busy) begin
      stage_reg <= stage_reg;
    end else if (ex_redirect) begin
      stage_reg <= ID_EX_BUBBLE;
    end else if (load_use) begin
      stage_reg <= ID_EX_BUBBLE;
      if (cnt_reg != '1) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end else begin
      stage_reg <= capture_next;
    end
  end

  assign valid_id_ex   = stage_reg.valid;
  assign ra_addr_id_ex = stage_reg.ra_addr;
  assign rb_addr_id_ex = stage_reg.rb_addr;
  assign rd_addr_id_ex = stage_reg.rd_addr;
  assign ra_data_id_ex = stage_reg.ra_data;
  assign rb_data_id_ex = stage_reg.rb_data;
  assign imm_id_ex     = stage_reg.imm;
  assign ctrl_id_ex    = stage_reg.ctrl;
  assign is_load_id_ex = stage_reg.is_load;
  assign lu_bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model compared every cycle plus directed literal checks.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  regaddr_t          id_ra_addr, id_rb_addr, id_rd_addr;
  u32_t              id_ra_data, id_rb_data, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_is_load, ex_redirect, mem_busy;
  logic              stall_if_id, valid_id_ex, is_load_id_ex;
  regaddr_t          ra_addr_id_ex, rb_addr_id_ex, rd_addr_id_ex;
  u32_t              ra_data_id_ex, rb_data_id_ex, imm_id_ex;
  logic [CTRL_W-1:0] ctrl_id_ex;
  logic [CNT_W-1:0]  lu_bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr), .id_rd_addr(id_rd_addr),
    .id_ra_data(id_ra_data), .id_rb_data(id_rb_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .stall_if_id(stall_if_id), .valid_id_ex(valid_id_ex),
    .ra_addr_id_ex(ra_addr_id_ex), .rb_addr_id_ex(rb_addr_id_ex),
    .rd_addr_id_ex(rd_addr_id_ex), .ra_data_id_ex(ra_data_id_ex),
    .rb_data_id_ex(rb_data_id_ex), .imm_id_ex(imm_id_ex), .ctrl_id_ex(ctrl_id_ex),
    .is_load_id_ex(is_load_id_ex), .lu_bubble_cnt(lu_bubble_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what EX should hold, tracked as plain fields.
  bit          m_started = 0;
  bit          m_valid, m_load;
  int unsigned m_ra, m_rb, m_rd, m_cnt;
  logic [31:0] m_ra_d, m_rb_d, m_imm;
  logic [15:0] m_ctrl;

  function automatic bit model_hazard();
    // ID depends on a load now in EX whose destination is a real register
    return id_valid && m_valid && m_load && m_rd != 0 &&
           (m_rd == id_ra_addr || m_rd == id_rb_addr);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_load = 0; m_ra = 0; m_rb = 0; m_rd = 0;
    m_ra_d = 0; m_rb_d = 0; m_imm = 0; m_ctrl = 0;
  endtask

  always @(posedge clk) begin
    bit hz;
    hz = model_hazard();
    if (rst) begin
      model_clear();
      m_cnt = 0;
      m_started = 1;
    end else if (!m_started || mem_busy) begin
      // frozen
    end else if (ex_redirect) begin
      model_clear();
    end else if (hz) begin
      model_clear();
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!id_valid) begin
      model_clear();
    end else begin
      m_valid = 1; m_load = id_is_load;
      m_ra = id_ra_addr; m_rb = id_rb_addr; m_rd = id_rd_addr;
      m_ra_d = id_ra_data; m_rb_d = id_rb_data; m_imm = id_imm; m_ctrl = id_ctrl;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("m_valid", 64'(valid_id_ex), 64'(m_valid));
      check("m_is_load", 64'(is_load_id_ex), 64'(m_load));
      check("m_ra_addr", 64'(ra_addr_id_ex), 64'(m_ra));
      check("m_rb_addr", 64'(rb_addr_id_ex), 64'(m_rb));
      check("m_rd_addr", 64'(rd_addr_id_ex), 64'(m_rd));
      check("m_ra_data", 64'(ra_data_id_ex), 64'(m_ra_d));
      check("m_rb_data", 64'(rb_data_id_ex), 64'(m_rb_d));
      check("m_imm", 64'(imm_id_ex), 64'(m_imm));
      check("m_ctrl", 64'(ctrl_id_ex), 64'(m_ctrl));
      check("m_cnt", 64'(lu_bubble_cnt), 64'(m_cnt));
      check("m_stall", 64'(stall_if_id), 64'(mem_busy || (model_hazard() && !ex_redirect)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int ra, input int rb, input int rd,
                        input logic [31:0] rad, input logic ld);
    id_valid = v; id_ra_addr = 5'(ra); id_rb_addr = 5'(rb); id_rd_addr = 5'(rd);
    id_ra_data = rad; id_rb_data = rad ^ 32'hFFFF_0000; id_imm = rad + 32'd4;
    id_ctrl = rad[15:0] ^ 16'h00A5; id_is_load = ld;
  endtask

  initial begin
    rst = 1; ex_redirect = 0; mem_busy = 0;
    set_id(0, 0, 0, 0, 32'h0, 0);
    tick(); tick();
    check("reset_valid", 64'(valid_id_ex), 64'd0);
    check("reset_cnt", 64'(lu_bubble_cnt), 64'd0);
    check("reset_ra_data", 64'(ra_data_id_ex), 64'd0);
    rst = 0;

    // 1: load r5 in EX, dependent in ID
    set_id(1, 1, 2, 5, 32'hAAAA_0001, 1); tick();
    $display("txn load rd=5 -> EX rd=%0d", rd_addr_id_ex);
    set_id(1, 5, 3, 6, 32'h0000_1234, 0); #1;
    check("t1_stall", 64'(stall_if_id), 64'd1);
    tick();
    $display("txn load-use bubble valid=%0d cnt=%0d", valid_id_ex, lu_bubble_cnt);
    check("t1_bubble_valid", 64'(valid_id_ex), 64'd0);
    check("t1_bubble_rd", 64'(rd_addr_id_ex), 64'd0);
    check("t1_cnt", 64'(lu_bubble_cnt), 64'd1);
    tick();
    check("t1_capture_rd", 64'(rd_addr_id_ex), 64'd6);
    check("t1_capture_data", 64'(ra_data_id_ex), 64'h0000_1234);

    // 2: load to r0, ID reads r0
    set_id(1, 1, 2, 0, 32'h0000_0BEE, 1); tick();
    set_id(1, 0, 0, 7, 32'h0000_7777, 0); #1;
    check("t2_stall", 64'(stall_if_id), 64'd0);
    tick();
    $display("txn r0 load no stall rd=%0d cnt=%0d", rd_addr_id_ex, lu_bubble_cnt);
    check("t2_rd", 64'(rd_addr_id_ex), 64'd7);
    check("t2_cnt", 64'(lu_bubble_cnt), 64'd1);

    // 3: load-use with simultaneous redirect
    set_id(1, 1, 2, 5, 32'h0000_0005, 1); tick();
    set_id(1, 3, 5, 8, 32'h0000_0008, 0); ex_redirect = 1; #1;
    check("t3_stall", 64'(stall_if_id), 64'd0);
    tick(); ex_redirect = 0;
    $display("txn redirect flush valid=%0d cnt=%0d", valid_id_ex, lu_bubble_cnt);
    check("t3_valid", 64'(valid_id_ex), 64'd0);
    check("t3_cnt", 64'(lu_bubble_cnt), 64'd1);

    // 4: freeze for three cycles while ID data changes
    set_id(1, 4, 9, 10, 32'h0000_1111, 0); tick();
    set_id(1, 4, 9, 10, 32'h0000_2222, 0); mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_stall", 64'(stall_if_id), 64'd1);
      tick();
      check("t4_hold", 64'(ra_data_id_ex), 64'h0000_1111);
    end
    mem_busy = 0; tick();
    $display("txn freeze release ra_data=0x%0h", ra_data_id_ex);
    check("t4_release", 64'(ra_data_id_ex), 64'h0000_2222);

    // 5: drive the counter past saturation
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      set_id(1, 1, 2, 5, 32'(i), 1); tick();
      set_id(1, 5, 5, 9, 32'(i), 0); tick();
    end
    $display("txn saturate cnt=%0d", lu_bubble_cnt);
    check("t5_saturate", 64'(lu_bubble_cnt), 64'(CNT_MAX));

    // 6: reset during freeze
    set_id(1, 2, 3, 11, 32'hDEAD_BEEF, 1); tick();
    mem_busy = 1; tick();
    rst = 1; tick();
    rst = 0; mem_busy = 0; set_id(0, 0, 0, 0, 32'h0, 0); #1;
    $display("txn reset in freeze valid=%0d cnt=%0d", valid_id_ex, lu_bubble_cnt);
    check("t6_valid", 64'(valid_id_ex), 64'd0);
    check("t6_data", 64'(ra_data_id_ex), 64'd0);
    check("t6_cnt", 64'(lu_bubble_cnt), 64'd0);
    check("t6_stall", 64'(stall_if_id), 64'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
